// File: rtl/trace_pkg.sv
// Shared definitions for the commit/trace producer: record width, flag bit
// positions and field offsets inside the 88-bit trace record.
package trace_pkg;

  localparam int TR_REC_W = 88;

  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMREAD  = 1;
  localparam int FLAG_MEMWRITE = 2;
  localparam int FLAG_HALT     = 3;

  // Record layout, MSB first: pc, inst, flags, dst, wdata, maddr, mdata.
  localparam int OFF_MDATA = 0;
  localparam int OFF_MADDR = 16;
  localparam int OFF_WDATA = 32;
  localparam int OFF_DST   = 48;
  localparam int OFF_FLAGS = 52;
  localparam int OFF_INST  = 56;
  localparam int OFF_PC    = 72;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records. Pointers carry one extra wrap bit so
// full and empty are told apart without an occupancy counter.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 88
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/commit_trace_unit.sv
// Commit/trace producer at the writeback boundary: packs qualifying retires
// into records, buffers them, and tracks counters, halt and watchdog status.
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CYCLE_LIMIT = 100000,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ret_valid,
  input  logic [15:0]         ret_pc,
  input  logic [15:0]         ret_inst,
  input  logic                ret_regwrite,
  input  logic [3:0]          ret_dst,
  input  logic [15:0]         ret_wdata,
  input  logic                ret_memread,
  input  logic                ret_memwrite,
  input  logic [15:0]         ret_maddr,
  input  logic [15:0]         ret_mdata,
  input  logic                ret_halt,
  output logic                stall_out,
  output logic                tr_valid,
  input  logic                tr_ready,
  output logic [TR_REC_W-1:0] tr_record,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    inst_count,
  output logic                halted,
  output logic                timeout,
  output logic                done
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  logic                qual;
  logic                accept;
  logic                wd_hit;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TR_REC_W-1:0] rec;

  assign qual      = ret_valid & (ret_regwrite | ret_memread | ret_memwrite | ret_halt);
  assign stall_out = fifo_full & ~halted & ~timeout;
  assign accept    = qual & ~stall_out & ~halted & ~timeout;
  assign wd_hit    = (cycle_count == LIMIT);
  assign tr_valid  = ~fifo_empty;
  assign done      = (halted | timeout) & fifo_empty;

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves a bit unassigned and infers a latch.
  always_comb begin
    rec = '0;
    rec[OFF_PC    +: 16] = ret_pc;
    rec[OFF_INST  +: 16] = ret_inst;
    rec[OFF_FLAGS + FLAG_REGWRITE] = ret_regwrite;
    rec[OFF_FLAGS + FLAG_MEMREAD]  = ret_memread;
    rec[OFF_FLAGS + FLAG_MEMWRITE] = ret_memwrite;
    rec[OFF_FLAGS + FLAG_HALT]     = ret_halt;
    rec[OFF_DST   +: 4]  = ret_dst;
    rec[OFF_WDATA +: 16] = ret_wdata;
    rec[OFF_MADDR +: 16] = ret_maddr;
    rec[OFF_MDATA +: 16] = ret_mdata;
  end

  trace_fifo #(.DEPTH(DEPTH), .W(TR_REC_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (tr_valid & tr_ready),
    .din   (rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (tr_record)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count <= '0;
      inst_count  <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      // The count stops at the limit so it reads exactly CYCLE_LIMIT once frozen.
      if (!halted && !timeout && !wd_hit && !(&cycle_count))
        cycle_count <= cycle_count + 1'b1;
      if (accept && !(&inst_count))
        inst_count <= inst_count + 1'b1;
      // A halt accepted on the watchdog edge takes priority over the timeout.
      if (accept && ret_halt)
        halted <= 1'b1;
      else if (!halted && wd_hit)
        timeout <= 1'b1;
    end
  end

endmodule
